// File: rtl/vergister_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write-back ports,
// reservation request and scoreboard status.
interface vergister_mp_if #(
   parameter int WIDTH       = 32,
   parameter int COUNT       = 32,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 1
);
   localparam int IDX = $clog2(COUNT);

   logic [READ_PORTS*IDX-1:0]    rd_addr;
   logic [READ_PORTS*WIDTH-1:0]  rd_data;
   logic [READ_PORTS-1:0]        rd_busy;
   logic [WRITE_PORTS-1:0]       wr_en;
   logic [WRITE_PORTS*IDX-1:0]   wr_addr;
   logic [WRITE_PORTS*WIDTH-1:0] wr_data;
   logic                         rsv_en;
   logic [IDX-1:0]               rsv_addr;
   logic [COUNT-1:0]             busy;
   logic                         wr_conflict;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, busy, wr_conflict
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, busy, wr_conflict
   );
endinterface

// File: rtl/vergister_mp.sv
// Multi-port register file with optional zero register, write-to-read bypass
// and a busy scoreboard for multi-cycle producers.
module vergister_mp #(
   parameter int WIDTH       = 32,
   parameter int COUNT       = 32,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 1,
   parameter int ZERO_REG    = 1,
   parameter int BYPASS      = 1
) (
   input logic            clk,
   input logic            reset,
   vergister_mp_if.slave  bus
);
   localparam int IDX = $clog2(COUNT);
   localparam logic [IDX:0] COUNT_W = COUNT[IDX:0];

   // An address is writable/readable storage only if in range and not the zero register.
   function automatic logic addr_ok(input logic [IDX-1:0] a);
      return ({1'b0, a} < COUNT_W) && !(ZERO_REG != 0 && a == '0);
   endfunction

   logic [WIDTH-1:0]       regs [COUNT];
   logic [COUNT-1:0]       busy_q;
   logic [COUNT-1:0]       busy_d;
   logic [WRITE_PORTS-1:0] wr_ok;
   logic                   conflict_d;
   logic                   conflict_q;

   always_comb begin
      wr_ok = '0;
      for (int w = 0; w < WRITE_PORTS; w++)
         wr_ok[w] = bus.wr_en[w] && addr_ok(bus.wr_addr[w*IDX +: IDX]);
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int w = 0; w < WRITE_PORTS; w++)
         for (int v = w + 1; v < WRITE_PORTS; v++)
            if (wr_ok[w] && wr_ok[v] && bus.wr_addr[w*IDX +: IDX] == bus.wr_addr[v*IDX +: IDX])
               conflict_d = 1'b1;
   end

   // Reservation is applied after write-back clears so a same-cycle reserve wins.
   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < WRITE_PORTS; w++)
         if (wr_ok[w])
            busy_d[bus.wr_addr[w*IDX +: IDX]] = 1'b0;
      if (bus.rsv_en && addr_ok(bus.rsv_addr))
         busy_d[bus.rsv_addr] = 1'b1;
   end

   // Ascending port scan lets the highest-numbered matching writer win the bypass.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int i = 0; i < READ_PORTS; i++) begin
         logic [IDX-1:0] a;
         a = bus.rd_addr[i*IDX +: IDX];
         if (addr_ok(a)) begin
            bus.rd_data[i*WIDTH +: WIDTH] = regs[a];
            bus.rd_busy[i]                = busy_q[a];
            if (BYPASS != 0) begin
               for (int w = 0; w < WRITE_PORTS; w++) begin
                  if (wr_ok[w] && bus.wr_addr[w*IDX +: IDX] == a) begin
                     bus.rd_data[i*WIDTH +: WIDTH] = bus.wr_data[w*WIDTH +: WIDTH];
                     bus.rd_busy[i]                = 1'b0;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < COUNT; r++)
            regs[r] <= '0;
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         for (int w = 0; w < WRITE_PORTS; w++)
            if (wr_ok[w])
               regs[bus.wr_addr[w*IDX +: IDX]] <= bus.wr_data[w*WIDTH +: WIDTH];
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.wr_conflict = conflict_q;
endmodule

// File: tb/tb_vergister_mp.sv
// Directed vector bench for vergister_mp: 2 read ports, 2 write ports,
// zero register and bypass enabled.
module tb_vergister_mp;
   localparam int WIDTH = 32;
   localparam int COUNT = 32;
   localparam int RP    = 2;
   localparam int WP    = 2;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   vergister_mp_if #(.WIDTH(WIDTH), .COUNT(COUNT), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

   vergister_mp #(
      .WIDTH(WIDTH), .COUNT(COUNT), .READ_PORTS(RP), .WRITE_PORTS(WP),
      .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        rsv;
      logic [4:0]  ra;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
      logic        ec;
      logic [31:0] ebusy;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic rsv, input logic [4:0] ra,
                        input logic [4:0] r0, input logic [4:0] r1);
      bus.wr_en    = wen;
      bus.wr_addr  = {wa1, wa0};
      bus.wr_data  = {wd1, wd0};
      bus.rsv_en   = rsv;
      bus.rsv_addr = ra;
      bus.rd_addr  = {r1, r0};
   endtask

   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
   endtask

   initial begin
      //          wen    wa0    wd0           wa1    wd1           rsv   ra     r0     r1     e0            e1            eb     ec    ebusy
      vecs[0]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd1,  32'h0,        32'h0,        2'b00, 1'b0, 32'h0};
      vecs[1]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0};
      vecs[2]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 1'b0, 32'h0};
      vecs[3]  = '{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 32'h0};
      vecs[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 32'h0};
      vecs[5]  = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       1'b0, 5'd0,  5'd7,  5'd7,  32'h22,       32'h22,       2'b00, 1'b0, 32'h0};
      vecs[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 2'b00, 1'b1, 32'h0};
      vecs[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,  32'h22,       32'h0,        2'b00, 1'b0, 32'h0};
      vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,        32'h22,       2'b00, 1'b0, 32'h0};
      vecs[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h0,        32'h0,        2'b11, 1'b0, 32'h8};
      vecs[10] = '{2'b01, 5'd3,  32'h55,       5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd5,  32'h55,       32'hDEADBEEF, 2'b00, 1'b0, 32'h8};
      vecs[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h55,       32'h55,       2'b00, 1'b0, 32'h0};
      vecs[12] = '{2'b10, 5'd0,  32'h0,        5'd3,  32'h66,       1'b1, 5'd3,  5'd3,  5'd3,  32'h66,       32'h66,       2'b00, 1'b0, 32'h0};
      vecs[13] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h66,       32'h66,       2'b11, 1'b0, 32'h8};
      vecs[14] = '{2'b11, 5'd9,  32'hA,        5'd10, 32'hB,        1'b0, 5'd0,  5'd9,  5'd10, 32'hA,        32'hB,        2'b00, 1'b0, 32'h8};
      vecs[15] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd10, 32'hA,        32'hB,        2'b00, 1'b0, 32'h8};
      vecs[16] = '{2'b11, 5'd31, 32'hFFFFFFFF, 5'd0,  32'h5,        1'b0, 5'd0,  5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,        2'b00, 1'b0, 32'h8};
      vecs[17] = '{2'b11, 5'd0,  32'h1,        5'd0,  32'h2,        1'b0, 5'd0,  5'd31, 5'd3,  32'hFFFFFFFF, 32'h66,       2'b10, 1'b0, 32'h8};
      vecs[18] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd31, 32'h0,        32'hFFFFFFFF, 2'b00, 1'b0, 32'h8};

      reset = 1'b1;
      idle(5'd0, 5'd0);
      #12;
      reset = 1'b0;

      // Reset state on every register and port.
      for (int a = 0; a < COUNT; a++) begin
         logic [4:0] aa;
         aa = a[4:0];
         idle(aa, aa);
         #1;
         check($sformatf("rst rd0 x%0d", a), bus.rd_data[31:0], 32'h0);
         check($sformatf("rst rd1 x%0d", a), bus.rd_data[63:32], 32'h0);
      end
      check("rst busy", bus.busy, 32'h0);
      check("rst rd_busy", {30'h0, bus.rd_busy}, 32'h0);
      check("rst conflict", {31'h0, bus.wr_conflict}, 32'h0);

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(vecs[i].wen, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
               vecs[i].rsv, vecs[i].ra, vecs[i].r0, vecs[i].r1);
         #2;
         check($sformatf("v%0d rd0", i), bus.rd_data[31:0], vecs[i].e0);
         check($sformatf("v%0d rd1", i), bus.rd_data[63:32], vecs[i].e1);
         check($sformatf("v%0d rd_busy", i), {30'h0, bus.rd_busy}, {30'h0, vecs[i].eb});
         check($sformatf("v%0d conflict", i), {31'h0, bus.wr_conflict}, {31'h0, vecs[i].ec});
         check($sformatf("v%0d busy", i), bus.busy, vecs[i].ebusy);
      end

      // Back-to-back collisions keep wr_conflict high, then it drops.
      @(negedge clk);
      drive(2'b11, 5'd8, 32'h1, 5'd8, 32'h2, 1'b0, 5'd0, 5'd8, 5'd8);
      @(negedge clk);
      drive(2'b11, 5'd8, 32'h3, 5'd8, 32'h4, 1'b0, 5'd0, 5'd8, 5'd8);
      #2;
      check("coll2 conflict", {31'h0, bus.wr_conflict}, 32'h1);
      @(negedge clk);
      idle(5'd8, 5'd0);
      #2;
      check("coll3 conflict", {31'h0, bus.wr_conflict}, 32'h1);
      check("coll3 x8", bus.rd_data[31:0], 32'h4);
      @(negedge clk);
      #2;
      check("coll4 conflict", {31'h0, bus.wr_conflict}, 32'h0);

      // Asynchronous reset while x3 is busy and holds data.
      @(negedge clk);
      drive(2'b01, 5'd3, 32'h55, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
      @(negedge clk);
      idle(5'd3, 5'd3);
      #2;
      check("pre-rst busy", bus.busy, 32'h8);
      check("pre-rst x3", bus.rd_data[31:0], 32'h55);
      check("pre-rst rd_busy", {30'h0, bus.rd_busy}, 32'h3);
      #1;
      reset = 1'b1;
      #1;
      check("async busy", bus.busy, 32'h0);
      check("async x3", bus.rd_data[31:0], 32'h0);
      check("async rd_busy", {30'h0, bus.rd_busy}, 32'h0);
      check("async conflict", {31'h0, bus.wr_conflict}, 32'h0);
      drive(2'b01, 5'd4, 32'h77, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
      @(negedge clk);
      idle(5'd4, 5'd3);
      reset = 1'b0;
      #2;
      check("lost wr x4", bus.rd_data[31:0], 32'h0);
      check("lost x3", bus.rd_data[63:32], 32'h0);
      check("lost rsv busy", bus.busy, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vergister_mp.md
Name: vergister_mp

Overview:
- Parametrised multi-port general-purpose register file, the successor to the two-read/one-write register file in the Vermicel core.
- Configurable width, depth, read-port count and write-port count; optional hardwired-zero register; optional same-cycle write-to-read bypass.
- Integrated busy scoreboard: multi-cycle units (divider, load unit) reserve a destination at issue and release it on write-back, so the issue stage can detect RAW hazards.
- Sits between decode/issue and the write-back stage.

Parameters:
- WIDTH, 32, data width of each register in bits.
- COUNT, 32, number of registers (>= 2); IDX = $clog2(COUNT) is the address width.
- READ_PORTS, 2, number of independent read ports (>= 1).
- WRITE_PORTS, 1, number of write ports (>= 1).
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never written or reserved.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  the clock signal.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  READ_PORTS*IDX  read address, port i at bits [i*IDX +: IDX].
- rd_data  out  READ_PORTS*WIDTH  read data, port i at bits [i*WIDTH +: WIDTH].
- rd_busy  out  READ_PORTS  port i's source register has a pending write.
- wr_en  in  WRITE_PORTS  write enable per write port.
- wr_addr  in  WRITE_PORTS*IDX  write address per port.
- wr_data  in  WRITE_PORTS*WIDTH  write data per port.
- rsv_en  in  1  reserve rsv_addr (mark busy) at the next edge.
- rsv_addr  in  IDX  register to reserve.
- busy  out  COUNT  scoreboard, bit r = register r has a pending write.
- wr_conflict  out  1  registered flag: a write collision happened in the previous cycle.

Behaviour:
- Reset (asynchronous, immediate on reset=1):
  - all registers = 0; busy = 0; wr_conflict = 0.
  - rd_data therefore reads 0 on every port, and rd_busy = 0.
- Writes, on posedge clk when not in reset:
  - for each port w with wr_en[w]=1, reg[wr_addr[w]] <= wr_data[w].
  - Addresses >= COUNT are ignored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Write collision (two or more enabled ports target the same non-ignored address in one cycle):
  - the highest-numbered port wins;
  - wr_conflict = 1 for exactly the following cycle, then returns to 0 unless the collision repeats.
- Reads are combinational:
  - rd_data[i] = reg[rd_addr[i]]; 0 for address 0 when ZERO_REG=1; 0 for address >= COUNT.
  - BYPASS=1: if an enabled write (the winning port on a collision) targets rd_addr[i] in the same cycle, rd_data[i] = that wr_data. Zero-register rule takes precedence.
  - BYPASS=0: the read returns the old value until after the edge.
- Scoreboard, per register r, on posedge clk:
  - rsv_en=1 and rsv_addr=r (valid, non-zero when ZERO_REG=1) -> busy[r] <= 1.
  - Else any enabled write to r -> busy[r] <= 0.
  - Else busy[r] holds.
  - Reserve and write to the same r in one cycle: reserve wins. The write completes the older operation; the new operation is now pending. busy stays 1 and the data is still written.
  - Reserving an already-busy register is legal; busy stays 1, no error.
  - busy[0] is constant 0 when ZERO_REG=1.
- Read hazards:
  - rd_busy[i] = busy[rd_addr[i]], except with BYPASS=1 it is 0 when a same-cycle enabled write targets rd_addr[i], because the data is forwarded.
  - With BYPASS=0 a same-cycle write does not clear rd_busy[i]; it clears on the next cycle via busy.
- Latency:
  - write-to-read: 0 cycles with BYPASS=1, 1 cycle otherwise;
  - reserve-to-busy: 1 cycle.
- Reset asserted mid-operation: all state clears immediately. Pending reservations are discarded; writes during reset are lost.

Test Plan:
- Reset then read all registers on every port -> all rd_data = 0, busy = 0, wr_conflict = 0.
- Write 0xDEADBEEF to x5 via port 0, then read x5 on both ports the next cycle -> 0xDEADBEEF. Same cycle with BYPASS=1 -> 0xDEADBEEF; with BYPASS=0 -> 0.
- ZERO_REG=1: write 0x1234 to x0 and rsv_en on x0, then read x0 -> rd_data = 0, busy[0] = 0.
- WRITE_PORTS=2: port0 writes 0x11 and port1 writes 0x22 to x7 in the same cycle -> x7 = 0x22, wr_conflict = 1 for one cycle, then 0.
- Reserve x3 -> busy[3] = 1 next cycle and rd_busy = 1 when reading x3. Then write x3 = 0x55 with BYPASS=1 -> rd_busy = 0 and rd_data = 0x55 that same cycle; busy[3] = 0 after the edge. Reserve and write x3 in one cycle -> busy[3] stays 1 and x3 is updated.
- Assert reset while busy[3] = 1 and x3 = 0x55 -> busy and x3 are 0 immediately, with no clock edge required.
